// File: rtl/cordic_vector_atan_pkg.sv
// Shared constants, state encoding and angle helpers for the vectoring-mode CORDIC.
package cordic_vector_atan_pkg;

  localparam int ANGLE_W    = 32;
  localparam int ANGLE_FRAC = 16;
  localparam int XY_FRAC    = 14;
  localparam int IDX_W      = 5;

  localparam logic signed [ANGLE_W-1:0] DEG180  = 32'sh00B4_0000;
  localparam logic signed [ANGLE_W-1:0] DEGM180 = 32'shFF4C_0000;
  localparam logic signed [ANGLE_W-1:0] DEG360  = 32'sh0168_0000;
  localparam logic [16:0]               INV_K_Q16 = 17'd39797;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  // Folds a result that overshot the +/-180 seam back into (-180, 180].
  function automatic logic signed [ANGLE_W-1:0] wrap_angle(input logic signed [ANGLE_W-1:0] z);
    logic signed [ANGLE_W-1:0] r;
    r = z;
    if (z > DEG180)
      r = z - DEG360;
    else if (z <= DEGM180)
      r = z + DEG360;
    return r;
  endfunction

endpackage

// File: rtl/xita_tan_lut.sv
// Registered table of atan(2^-i) in degrees, 16.16 fixed point; one cycle of latency.
module xita_tan_lut
  import cordic_vector_atan_pkg::*;
(
  input  logic                 clk,
  input  logic [IDX_W-1:0]     idx,
  output logic [ANGLE_W-1:0]   theta
);

  always_ff @(posedge clk) begin
    case (idx)
      5'd0:    theta <= 32'd2949120;
      5'd1:    theta <= 32'd1740967;
      5'd2:    theta <= 32'd919879;
      5'd3:    theta <= 32'd466945;
      5'd4:    theta <= 32'd234379;
      5'd5:    theta <= 32'd117304;
      5'd6:    theta <= 32'd58666;
      5'd7:    theta <= 32'd29335;
      5'd8:    theta <= 32'd14668;
      5'd9:    theta <= 32'd7334;
      5'd10:   theta <= 32'd3667;
      5'd11:   theta <= 32'd1833;
      5'd12:   theta <= 32'd917;
      5'd13:   theta <= 32'd458;
      5'd14:   theta <= 32'd229;
      5'd15:   theta <= 32'd115;
      5'd16:   theta <= 32'd57;
      5'd17:   theta <= 32'd29;
      5'd18:   theta <= 32'd14;
      5'd19:   theta <= 32'd7;
      5'd20:   theta <= 32'd4;
      default: theta <= 32'd0;
    endcase
  end

endmodule

// File: rtl/cordic_vector_atan.sv
// Iterative vectoring-mode CORDIC: atan2(y, x) in 16.16 degrees plus vector magnitude.
//   state | meaning
//   IDLE  | waiting for start, outputs hold last result
//   LOAD  | pre-rotate into the right half-plane, present table index 0
//   ITER  | one micro-rotation per cycle, i = 0..N_ITER-1
//   DONE  | register angle/mag, pulse done on the following cycle
module cordic_vector_atan
  import cordic_vector_atan_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int N_ITER    = 21,
  parameter int GAIN_COMP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   x_in,
  input  logic [DATA_W-1:0]   y_in,
  output logic                busy,
  output logic                done,
  output logic [ANGLE_W-1:0]  angle,
  output logic [DATA_W+1:0]   mag
);

  // DATA_W+3 integer bits keep the most negative input plus CORDIC gain in range;
  // the fraction bits hold shift truncation well below the angle tolerance.
  localparam int XY_W = DATA_W + 3 + XY_FRAC;
  localparam int MW   = DATA_W + 2;
  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N_ITER - 1);

  state_t                    state_q, state_d;
  logic [DATA_W-1:0]         x_cap, y_cap, x_cap_d, y_cap_d;
  logic signed [XY_W-1:0]    xq, yq, x_d, y_d;
  logic signed [ANGLE_W-1:0] zq, z_d;
  logic [IDX_W-1:0]          iter_q, iter_d, lut_idx;
  logic                      busy_d, done_d;
  logic [ANGLE_W-1:0]        angle_d;
  logic [MW-1:0]             mag_d;

  logic [ANGLE_W-1:0]        theta;
  logic signed [XY_W-1:0]    x_ext, y_ext, xs, ys;
  logic [XY_W+16:0]          prod;
  logic [MW-1:0]             mag_calc;
  logic                      x_neg;

  xita_tan_lut u_lut (
    .clk   (clk),
    .idx   (lut_idx),
    .theta (theta)
  );

  assign x_neg = x_cap[DATA_W-1];
  assign x_ext = {{3{x_cap[DATA_W-1]}}, x_cap, {XY_FRAC{1'b0}}};
  assign y_ext = {{3{y_cap[DATA_W-1]}}, y_cap, {XY_FRAC{1'b0}}};
  assign xs    = xq >>> iter_q;
  assign ys    = yq >>> iter_q;
  assign prod  = {17'd0, xq} * {{XY_W{1'b0}}, INV_K_Q16};
  assign mag_calc = (GAIN_COMP != 0) ? MW'(prod >> (ANGLE_FRAC + XY_FRAC))
                                     : MW'(xq >> XY_FRAC);

  always_comb begin
    state_d = state_q;
    x_cap_d = x_cap;
    y_cap_d = y_cap;
    x_d     = xq;
    y_d     = yq;
    z_d     = zq;
    iter_d  = iter_q;
    lut_idx = '0;
    busy_d  = busy;
    done_d  = 1'b0;
    angle_d = angle;
    mag_d   = mag;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_cap_d = x_in;
          y_cap_d = y_in;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        x_d     = x_neg ? -x_ext : x_ext;
        y_d     = x_neg ? -y_ext : y_ext;
        z_d     = x_neg ? (y_cap[DATA_W-1] ? DEGM180 : DEG180) : '0;
        iter_d  = '0;
        state_d = ITER;
      end
      ITER: begin
        // Table is registered, so look one index ahead of the rotation in flight.
        lut_idx = iter_q + 5'd1;
        if (yq[XY_W-1]) begin
          x_d = xq - ys;
          y_d = yq + xs;
          z_d = zq - $signed(theta);
        end else begin
          x_d = xq + ys;
          y_d = yq - xs;
          z_d = zq + $signed(theta);
        end
        if (iter_q == LAST_I) begin
          iter_d  = '0;
          state_d = DONE;
        end else begin
          iter_d = iter_q + 5'd1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        // A vector on the x axis gets an exact answer instead of the converged residue.
        if (y_cap == '0)
          angle_d = x_neg ? DEG180 : '0;
        else
          angle_d = wrap_angle(zq);
        mag_d   = mag_calc;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_cap   <= '0;
      y_cap   <= '0;
      xq      <= '0;
      yq      <= '0;
      zq      <= '0;
      iter_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      angle   <= '0;
      mag     <= '0;
    end else begin
      state_q <= state_d;
      x_cap   <= x_cap_d;
      y_cap   <= y_cap_d;
      xq      <= x_d;
      yq      <= y_d;
      zq      <= z_d;
      iter_q  <= iter_d;
      busy    <= busy_d;
      done    <= done_d;
      angle   <= angle_d;
      mag     <= mag_d;
    end
  end

endmodule

// File: tb/tb_cordic_vector_atan.sv
// Self-checking bench for cordic_vector_atan: scoreboard of expected angle/magnitude windows.
module tb_cordic_vector_atan;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] x_in, y_in;
  logic        busy, done;
  logic [31:0] angle;
  logic [17:0] mag;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int ang;
    int tol;
    int mlo;
    int mhi;
  } exp_t;

  exp_t sb[$];

  cordic_vector_atan #(.DATA_W(16), .N_ITER(21), .GAIN_COMP(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x_in  (x_in),
    .y_in  (y_in),
    .busy  (busy),
    .done  (done),
    .angle (angle),
    .mag   (mag)
  );

  always #5 clk = ~clk;

  // Expected window from real-valued atan2 / hypot.
  task automatic push_expect(input int x, input int y, input int tol);
    exp_t e;
    real  a, m;
    a = $atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979;
    m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    e.ang = $rtoi(a * 65536.0 + ((a >= 0.0) ? 0.5 : -0.5));
    e.tol = tol;
    e.mlo = $rtoi(m * 0.99 - 2.0);
    if (e.mlo < 0) e.mlo = 0;
    e.mhi = $rtoi(m * 1.01 + 2.0) + 1;
    sb.push_back(e);
  endtask

  task automatic launch(input int x, input int y);
    @(negedge clk);
    start = 1'b1;
    x_in  = 16'(x);
    y_in  = 16'(y);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; x_in = '0; y_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (angle !== 32'd0) begin failures++; $display("FAIL reset_angle: got %h want 0", angle); end
    checks++; if (mag !== 18'd0)  begin failures++; $display("FAIL reset_mag: got %0d want 0", mag); end
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    int vx[] = '{100, 100, 0, -100, -100, 0, -32768, 16, -16};
    int vy[] = '{0, 100, 100, 0, -100, 0, -32768, 16, -16};
    int cyc, d, x, y;
    bit seen;
    exp_t e;
    for (int i = 0; i < vx.size() + 6; i++) begin
      if (i < vx.size()) begin
        x = vx[i]; y = vy[i];
      end else begin
        x = int'($urandom_range(16, 32767)); if ($urandom_range(0, 1) == 1) x = -x;
        y = int'($urandom_range(16, 32767)); if ($urandom_range(0, 1) == 1) y = -y;
      end
      if (x == 0 && y == 0) begin
        e.ang = 0; e.tol = 0; e.mlo = 0; e.mhi = 0;
        sb.push_back(e);
      end else begin
        push_expect(x, y, (y == 0) ? 0 : 655);
      end
      launch(x, y);
      wait_done(cyc, seen);
      checks++;
      if (!seen || cyc != 23) begin
        failures++; $display("FAIL vec%0d_latency: got %0d cycles (seen=%0b) want 23", i, cyc, seen);
      end
      e = sb.pop_front();
      d = int'($signed(angle)) - e.ang;
      if (d < 0) d = -d;
      checks++;
      if (d > e.tol) begin
        failures++; $display("FAIL vec%0d_angle (%0d,%0d): got %0d want %0d +/- %0d", i, x, y, int'($signed(angle)), e.ang, e.tol);
      end
      checks++;
      if (int'(mag) < e.mlo || int'(mag) > e.mhi) begin
        failures++; $display("FAIL vec%0d_mag (%0d,%0d): got %0d want %0d..%0d", i, x, y, mag, e.mlo, e.mhi);
      end
    end
  endtask

  task automatic test_ignore_start();
    int cyc, d, n;
    bit seen;
    exp_t e;
    push_expect(100, 100, 655);
    launch(100, 100);
    repeat (8) @(posedge clk);
    @(negedge clk);
    start = 1'b1; x_in = 16'(-100); y_in = 16'(-100);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL ignore_done: no done seen"); end
    e = sb.pop_front();
    d = int'($signed(angle)) - e.ang;
    if (d < 0) d = -d;
    checks++;
    if (d > e.tol) begin
      failures++; $display("FAIL ignore_angle: got %0d want %0d +/- %0d", int'($signed(angle)), e.ang, e.tol);
    end
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    checks++;
    if (n != 0) begin failures++; $display("FAIL ignore_extra_done: got %0d pulses want 0", n); end
  endtask

  task automatic test_back_to_back();
    int cyc, d;
    bit seen;
    exp_t e;
    push_expect(300, 400, 655);
    launch(300, 400);
    wait_done(cyc, seen);
    checks++;
    if (!seen || busy !== 1'b0) begin
      failures++; $display("FAIL b2b_first_done: seen=%0b busy=%b want seen=1 busy=0", seen, busy);
    end
    e = sb.pop_front();
    d = int'($signed(angle)) - e.ang;
    if (d < 0) d = -d;
    checks++;
    if (d > e.tol) begin
      failures++; $display("FAIL b2b_first_angle: got %0d want %0d +/- %0d", int'($signed(angle)), e.ang, e.tol);
    end
    push_expect(-500, 1200, 655);
    start = 1'b1; x_in = 16'(-500); y_in = 16'(1200);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, seen);
    checks++;
    if (!seen || cyc != 23) begin
      failures++; $display("FAIL b2b_latency: got %0d cycles (seen=%0b) want 23", cyc, seen);
    end
    e = sb.pop_front();
    d = int'($signed(angle)) - e.ang;
    if (d < 0) d = -d;
    checks++;
    if (d > e.tol) begin
      failures++; $display("FAIL b2b_second_angle: got %0d want %0d +/- %0d", int'($signed(angle)), e.ang, e.tol);
    end
    checks++;
    if (int'(mag) < e.mlo || int'(mag) > e.mhi) begin
      failures++; $display("FAIL b2b_second_mag: got %0d want %0d..%0d", mag, e.mlo, e.mhi);
    end
  endtask

  task automatic test_reset_abort();
    int n, cyc, d;
    bit seen;
    exp_t e;
    launch(200, -50);
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin failures++; $display("FAIL abort_done: got %b want 0", done); end
    checks++; if (angle !== 32'd0) begin failures++; $display("FAIL abort_angle: got %h want 0", angle); end
    checks++; if (mag !== 18'd0)  begin failures++; $display("FAIL abort_mag: got %0d want 0", mag); end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    checks++;
    if (n != 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses want 0", n); end
    push_expect(-100, -100, 655);
    launch(-100, -100);
    wait_done(cyc, seen);
    checks++;
    if (!seen || cyc != 23) begin
      failures++; $display("FAIL abort_recover_latency: got %0d cycles (seen=%0b) want 23", cyc, seen);
    end
    e = sb.pop_front();
    d = int'($signed(angle)) - e.ang;
    if (d < 0) d = -d;
    checks++;
    if (d > e.tol) begin
      failures++; $display("FAIL abort_recover_angle: got %0d want %0d +/- %0d", int'($signed(angle)), e.ang, e.tol);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
